// File: rtl/sr_flag_arbiter_pkg.sv
// Opcodes and FSM state encodings for the flag bank arbiter.
// No ports; imported by the interface, cell and top.
package sr_flag_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester/flag bus: req, lock, op, idx in; gnt, q, qbar,
// busy, idx_err, lock_err out. slave = arbiter, master = requesters.
interface sr_flag_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = 3
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [2*NUM_REQ-1:0]     op;
  logic [IDX_W*NUM_REQ-1:0] idx;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_FLAGS-1:0]     q;
  logic [NUM_FLAGS-1:0]     qbar;
  logic                     busy;
  logic                     idx_err;
  logic                     lock_err;

  modport master (
    output req, lock, op, idx,
    input  gnt, q, qbar, busy, idx_err, lock_err
  );

  modport slave (
    input  req, lock, op, idx,
    output gnt, q, qbar, busy, idx_err, lock_err
  );

endinterface

// File: rtl/sr_flag_arbiter_cell.sv
// One set/reset flag bit; 11 toggles, so the cell never goes X.
// Ports: clk, rst (sync high), en, op[1:0] in; q, qbar out.
module sr_flag_cell
  import sr_flag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] op,
  output logic       q,
  output logic       qbar
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (op)
        OP_CLR:  q_d = 1'b0;
        OP_SET:  q_d = 1'b1;
        OP_TGL:  q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter with lock/timeout over a bank of flag cells.
// Ports: clk, rst (sync high), bus (sr_flag_arbiter_if.slave).
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = 3,
  parameter int LOCK_MAX  = 16
) (
  input logic              clk,
  input logic              rst,
  sr_flag_arbiter_if.slave bus
);

  localparam int PTR_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W =
    (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(LOCK_MAX - 1);
  localparam logic [IDX_W:0] FLAGS =
    (IDX_W + 1)'(NUM_FLAGS);

  state_e state_q;
  state_e state_d;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] owner_q;
  logic [PTR_W-1:0] owner_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] gnt_d;
  logic idx_err_q;
  logic idx_err_d;
  logic lock_err_q;
  logic lock_err_d;

  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] sel;
  logic             hit;
  logic             go;
  int               sel_i;

  logic [1:0]           op_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 oob;
  logic [NUM_FLAGS-1:0] en;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int c;
    c   = 0;
    hit = 1'b0;
    win = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!hit && bus.req[c]) begin
        hit = 1'b1;
        win = PTR_W'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    go         = 1'b0;
    sel        = win;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          go    = 1'b1;
          ptr_d = nxt(win);
          if (bus.lock[win]) begin
            state_d = ST_LOCKED;
            owner_d = win;
            cnt_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        sel   = owner_q;
        go    = bus.req[owner_q];
        cnt_d = cnt_q + 1'b1;
        // Either exit path leaves the owner last in line.
        if (!bus.lock[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = nxt(owner_q);
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d    = ST_IDLE;
          ptr_d      = nxt(owner_q);
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel_i = int'(sel);
  assign op_s  = bus.op[2*sel_i +: 2];
  assign idx_s = bus.idx[IDX_W*sel_i +: IDX_W];
  assign oob   = ({1'b0, idx_s} >= FLAGS);

  always_comb begin
    gnt_d = '0;
    if (go) gnt_d[sel] = 1'b1;
  end

  assign idx_err_d = go && oob;

  for (genvar f = 0; f < NUM_FLAGS; f++) begin : g_cell
    assign en[f] = go && !oob &&
                   (idx_s == IDX_W'(f));

    sr_flag_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en[f]),
      .op   (op_s),
      .q    (bus.q[f]),
      .qbar (bus.qbar[f])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      idx_err_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      idx_err_q  <= idx_err_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q == ST_LOCKED);
  assign bus.idx_err  = idx_err_q;
  assign bus.lock_err = lock_err_q;

endmodule
